// File: rtl/gcd_arb_pkg.sv
// -----------------------------------------------------------------------------
// gcd_arb_pkg
//   Shared definitions for the gcd_arbiter front end: FSM state encoding and
//   the default requester count / operand width.
//   No ports (package).
// -----------------------------------------------------------------------------
package gcd_arb_pkg;

    localparam int DEFAULT_W    = 8;
    localparam int DEFAULT_NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/gcd_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: the winner is the first set request
//   bit at or after ptr, searching modulo NREQ.
//   Ports:
//     req   in  NREQ  request vector
//     ptr   in  IDXW  search start position
//     grant out NREQ  one-hot grant (all zero when no request)
//     idx   out IDXW  encoded winner index (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
    import gcd_arb_pkg::*;
#(
    parameter  int NREQ = DEFAULT_NREQ,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx
);

    logic found;

    // NREQ need not be a power of two, so the wrap is an explicit modulo.
    function automatic logic [IDXW-1:0] wrap_idx(input int unsigned v);
        return IDXW'(v % NREQ);
    endfunction

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[wrap_idx(32'(ptr) + 32'(k))]) begin
                found = 1'b1;
                idx   = wrap_idx(32'(ptr) + 32'(k));
            end
        end
        if (found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_arbiter
//   Round-robin front end sharing one gcd engine among NREQ requesters.
//   Accepts one operand pair at a time, pulses GCD_START, waits for GCD_DONE
//   and returns the result to the owning requester as a one-cycle pulse.
//   Optional watchdog: define GCD_ARB_TIMEOUT_EN to abort a job after TIMEOUT
//   cycles in WAIT (RSP_ERROR=1, RSP_TIMEOUT=1). Without it WAIT waits forever
//   and RSP_TIMEOUT is tied low.
//   Ports:
//     CLK, RST_N          clock (rising), async active-low reset
//     REQ_VALID/READY     per-requester handshake, READY one-hot, IDLE only
//     REQ_A, REQ_B        packed operands, slice i = [i*W +: W]
//     RSP_VALID           one-hot result pulse to the job owner
//     RSP_Y, RSP_ERROR    result / error (Y forced to 0 on error)
//     RSP_TIMEOUT         job aborted by watchdog
//     BUSY                high outside IDLE
//     GCD_START/A/B       engine command (A/B held from ISSUE until DONE)
//     GCD_Y/DONE/ERROR    engine response
// -----------------------------------------------------------------------------
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int NREQ    = DEFAULT_NREQ,
    parameter int W       = DEFAULT_W,
    parameter int TIMEOUT = 600
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ_VALID,
    input  logic [NREQ*W-1:0] REQ_A,
    input  logic [NREQ*W-1:0] REQ_B,
    output logic [NREQ-1:0]   REQ_READY,
    output logic [NREQ-1:0]   RSP_VALID,
    output logic [W-1:0]      RSP_Y,
    output logic              RSP_ERROR,
    output logic              RSP_TIMEOUT,
    output logic              BUSY,
    output logic              GCD_START,
    output logic [W-1:0]      GCD_A,
    output logic [W-1:0]      GCD_B,
    input  logic [W-1:0]      GCD_Y,
    input  logic              GCD_DONE,
    input  logic              GCD_ERROR
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state, state_nxt;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] owner;
    logic [W-1:0]    op_a, op_b;
    logic [W-1:0]    res_y;
    logic            res_err;
    logic            any_req;
    logic            timeout_hit;
    logic [NREQ-1:0] grant;
    logic [IDXW-1:0] win_idx;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (REQ_VALID),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    assign any_req = |REQ_VALID;
    assign GCD_A   = op_a;
    assign GCD_B   = op_b;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] wd_cnt;
    logic            res_to;

    // wd_cnt is 0 in the first WAIT cycle, so the abort lands exactly
    // TIMEOUT cycles after WAIT entry. A DONE in that same cycle wins.
    assign timeout_hit = (state == ST_WAIT) && (wd_cnt == CNTW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_cnt <= '0;
            res_to <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (state == ST_WAIT) begin
                res_to <= !GCD_DONE && timeout_hit;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign timeout_hit        = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            owner   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res_y   <= '0;
            res_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        op_a  <= REQ_A[win_idx*W +: W];
                        op_b  <= REQ_B[win_idx*W +: W];
                        owner <= win_idx;
                        ptr   <= (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (GCD_DONE) begin
                        res_y   <= GCD_Y;
                        res_err <= GCD_ERROR;
                    end else if (timeout_hit) begin
                        res_y   <= '0;
                        res_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        REQ_READY   = '0;
        RSP_VALID   = '0;
        RSP_Y       = '0;
        RSP_ERROR   = 1'b0;
        RSP_TIMEOUT = 1'b0;
        GCD_START   = 1'b0;
        BUSY        = 1'b1;
        unique case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                // The grant is combinational from REQ_VALID; gating with
                // RST_N keeps READY low while reset is held.
                if (RST_N) begin
                    REQ_READY = grant;
                end
                if (any_req) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                GCD_START = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (GCD_DONE || timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                RSP_VALID[owner] = 1'b1;
                RSP_ERROR        = res_err;
                RSP_Y            = res_err ? '0 : res_y;
`ifdef GCD_ARB_TIMEOUT_EN
                RSP_TIMEOUT      = res_to;
`endif
                state_nxt        = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
